alu_program_sequencer: RTL
==========================

Name: alu_program_sequencer

Overview:
- Small instruction sequencer that shares the team's combinational 16-bit ALU with a 16-entry register file.
- A short program is loaded into internal instruction memory. A start pulse then runs it from address 0.
- For each instruction the block reads operands, drives the ALU, and writes the result and flags back.
- It sits between the board I/O logic (buttons/switches) and the ALU; the ALU is instantiated outside and connected through the alu_* ports.

Parameters:
- PROG_AW, 4, instruction-memory address width; depth = 2^PROG_AW.
- WAIT_OP, 8'h00, opcode that performs no writeback and no flag update.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle run request; honoured only when idle
- prog_we  in  1  instruction-memory write enable; honoured only when idle
- prog_addr  in  PROG_AW  instruction-memory write address
- prog_data  in  21  instruction word: [20] imm_sel, [19:12] opcode, [11:8] rdest, [7:0] src field
- prog_len  in  PROG_AW+1  number of instructions to run, sampled on start
- alu_opcode  out  8  opcode to ALU
- alu_a  out  16  Rdest operand to ALU
- alu_b  out  16  Rsrc/immediate operand to ALU
- alu_result  in  16  ALU result (combinational)
- alu_flags  in  5  ALU flags (combinational)
- busy  out  1  high while a program runs
- done  out  1  one-cycle pulse after the last writeback
- pc  out  PROG_AW  address of the current instruction
- flags  out  5  architectural flags register
- dbg_addr  in  4  register-file read address for display
- dbg_data  out  16  regfile[dbg_addr], combinational

Behaviour:
- Reset (async, active-low) clears:
  - state to IDLE; busy, done, pc to 0; flags to 0;
  - all 16 registers to 0; internal instr/result/flag capture registers to 0;
  - alu_opcode/alu_a/alu_b to 0.
  - Instruction memory is NOT reset; its contents are retained.
- Reset mid-run aborts immediately; no partial writeback completes.
- States: IDLE, FETCH, EXEC, WB.
- IDLE:
  - alu_* outputs are driven 0.
  - prog_we writes prog_data into mem[prog_addr] at the clock edge.
  - start at edge E0 latches len_q = prog_len and sets pc = 0.
  - If len_q is 0: stay IDLE, pulse done for the next cycle, busy stays 0.
  - Otherwise: go to FETCH and set busy = 1.
  - If start and prog_we are asserted in the same cycle, the write happens and the run starts; the written word is visible to the run.
- FETCH: at the edge, instr_q <= mem[pc]; go to EXEC.
- EXEC (combinational outputs):
  - alu_opcode = instr_q opcode.
  - alu_a = regfile[rdest].
  - alu_b = regfile[src[3:0]] when imm_sel = 0; otherwise the sign-extended 8-bit immediate {{8{src[7]}}, src}.
  - At the edge, res_q <= alu_result and flg_q <= alu_flags; go to WB.
  - alu_* outputs hold their values through WB.
- WB:
  - At the edge, if opcode != WAIT_OP: regfile[rdest] <= res_q and flags <= flg_q. If opcode == WAIT_OP, both hold.
  - If pc == len_q-1: go to IDLE, busy <= 0, done <= 1 for one cycle, pc holds.
  - Otherwise: pc <= pc+1 and go to FETCH.
- Timing: each instruction takes 3 cycles.
  - Writeback of instruction i (0-based) occurs at edge E0+3(i+1).
  - done is high and busy is low in the cycle following edge E0+3N.
- Hazards: register reads in EXEC see all earlier writebacks. rdest == rsrc is legal and reads the old value.
- While busy, start and prog_we are ignored; memory is unchanged.
- prog_len of 2^PROG_AW runs the full memory. Larger values are clamped to 2^PROG_AW.
- pc never wraps.
- done never asserts while busy is high.

Test Plan:
- Bench ALU model: opcode 0x05 gives result = a+b, flags[0] = carry; opcode 0x09 gives result = a-b, flags[1] = zero when result is 0.
- Reset: assert reset_n=0 mid-run -> busy=0, done=0, pc=0, flags=0, dbg_data=0 for all 16 addresses; previously loaded program reruns identically after start.
- Immediate add:
  - Program: [0] {1,0x05,r1,0x07}; [1] {1,0x05,r1,0xFE}; prog_len=2; start.
  - Required: r1=0x0007 at edge E0+3; r1=0x0005 at E0+6; flags[0]=1 (carry from 0x0007+0xFFFE); done pulses exactly one cycle after E0+6.
- Register op and WAIT:
  - Preload r2=0x0003 and r3=0x0003 via immediates, then run {0,0x09,r2,r3}, then {x,0x00,r2,x}.
  - Required: r2=0x0000, flags[1]=1; the WAIT instruction leaves r2 and flags unchanged while still taking 3 cycles.
- Zero length: prog_len=0 with start -> busy stays 0, done=1 for exactly one cycle, no register changes.
- Ignored requests while busy: during a 4-instruction run, pulse start and prog_we (addr 0, data 0x1FFFFF) -> run completes unaffected, mem[0] unchanged, done pulses once.
- Full memory: 16 instructions each adding immediate 1 to r4, prog_len=16 -> r4=0x0010, pc=15 at done, done at E0+48.

Source files
------------

// File: rtl/alu_program_sequencer_if.sv
// ALU bus between the program sequencer (master) and the shared combinational ALU (slave).
interface alu_program_sequencer_if;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;

  modport master (
    output alu_opcode,
    output alu_a,
    output alu_b,
    input  alu_result,
    input  alu_flags
  );

  modport slave (
    input  alu_opcode,
    input  alu_a,
    input  alu_b,
    output alu_result,
    output alu_flags
  );
endinterface

// File: rtl/alu_program_sequencer.sv
// Runs a short program from internal instruction memory through an external ALU,
// writing results and flags back to a 16-entry register file.
//
// state | meaning
// IDLE  | waiting for start; program memory writable; ALU bus driven to zero
// FETCH | instr_q <= mem[pc]
// EXEC  | operands on ALU bus; result and flags captured at the edge
// WB    | result/flags committed (unless WAIT_OP); advance pc or finish
module alu_program_sequencer #(
  parameter int          PROG_AW = 4,
  parameter logic [7:0]  WAIT_OP = 8'h00
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       prog_we,
  input  logic [PROG_AW-1:0]         prog_addr,
  input  logic [20:0]                prog_data,
  input  logic [PROG_AW:0]           prog_len,
  alu_program_sequencer_if.master    alu,
  output logic                       busy,
  output logic                       done,
  output logic [PROG_AW-1:0]         pc,
  output logic [4:0]                 flags,
  input  logic [3:0]                 dbg_addr,
  output logic [15:0]                dbg_data
);

  localparam int                 DEPTH     = 1 << PROG_AW;
  localparam logic [PROG_AW:0]   DEPTH_LEN = (PROG_AW+1)'(DEPTH);
  localparam logic [PROG_AW:0]   LEN_ONE   = (PROG_AW+1)'(1);
  localparam logic [PROG_AW-1:0] PC_ONE    = PROG_AW'(1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [20:0]        mem [DEPTH];
  logic [20:0]        instr_q;
  logic [15:0]        res_q;
  logic [4:0]         flg_q;
  logic [15:0]        regfile [16];
  logic [PROG_AW:0]   len_q;
  logic [PROG_AW:0]   len_clamped;
  logic [PROG_AW:0]   len_m1;
  logic               last_instr;

  logic               imm_sel;
  logic [7:0]         opcode;
  logic [3:0]         rdest;
  logic [7:0]         src;

  assign imm_sel = instr_q[20];
  assign opcode  = instr_q[19:12];
  assign rdest   = instr_q[11:8];
  assign src     = instr_q[7:0];

  assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign len_m1      = len_q - LEN_ONE;
  assign last_instr  = ({1'b0, pc} == len_m1);

  assign dbg_data = regfile[dbg_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (len_clamped != '0)) state_nxt = FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = last_instr ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands stay on the bus through WB; the regfile only changes at the end of WB.
  always_comb begin
    alu.alu_opcode = '0;
    alu.alu_a      = '0;
    alu.alu_b      = '0;
    if ((state == EXEC) || (state == WB)) begin
      alu.alu_opcode = opcode;
      alu.alu_a      = regfile[rdest];
      alu.alu_b      = imm_sel ? {{8{src[7]}}, src} : regfile[src[3:0]];
    end
  end

  // Instruction memory is deliberately left out of reset so a program survives it.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q   <= '0;
      pc      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      instr_q <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      flags   <= '0;
      for (int i = 0; i < 16; i++) begin
        regfile[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len_clamped;
            pc    <= '0;
            if (len_clamped == '0) begin
              done <= 1'b1;
            end else begin
              busy <= 1'b1;
            end
          end
        end
        FETCH: instr_q <= mem[pc];
        EXEC: begin
          res_q <= alu.alu_result;
          flg_q <= alu.alu_flags;
        end
        WB: begin
          if (opcode != WAIT_OP) begin
            regfile[rdest] <= res_q;
            flags          <= flg_q;
          end
          if (last_instr) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            pc <= pc + PC_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
